// File: rtl/eth_udp_drop_filter_if.sv
// 64-bit AXI-Stream beat bundle (no tready) shared by the RX filter's input and output.
interface eth_udp_drop_filter_if;
  logic        tvalid;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser);
  modport slave  (input  tvalid, tdata, tkeep, tlast, tuser);
endinterface

// File: rtl/eth_udp_drop_filter.sv
// Inline IPv4/UDP port drop filter (DNS blocking) on the 10G RX path; fail-open when undecided.
// Fixed 5-cycle latency; no backpressure (stream has no tready), dropped frames just lose tvalid.
module eth_udp_drop_filter #(
  parameter int CNT_W     = 32,
  parameter bit MATCH_SRC = 1'b0
) (
  input  logic                         clk156,
  input  logic                         eth_rst,
  input  logic                         filter_en,
  input  logic [15:0]                  filter_port,
  eth_udp_drop_filter_if.slave         s_axis,
  eth_udp_drop_filter_if.master        m_axis,
  output logic [CNT_W-1:0]             pass_cnt,
  output logic [CNT_W-1:0]             drop_cnt,
  output logic [CNT_W-1:0]             undec_cnt,
  output logic [7:0]                   debug
);

  typedef enum logic [1:0] {SYNC, HEAD, BODY} state_e;

  typedef struct packed {
    logic        vld;
    logic        sop;
    logic [63:0] dat;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  state_e      state_q, state_d;
  logic [2:0]  rx_cnt_q, rx_cnt_d;
  logic        in_vld, beat0, beat1, beat2, beat4;

  beat_t       in_beat;
  beat_t [4:0] pipe_q;
  beat_t       s5;

  logic [15:0] ftype_q;
  logic [7:0]  verbyte_q, proto_q;
  logic [15:0] dport, sport;
  logic        port_hit;
  logic        dec_vld_q, dec_drop_q;
  logic        out_drop_q, out_undec_q;
  logic        drop_now, undec_now;
  logic [CNT_W-1:0] pass_cnt_q, drop_cnt_q, undec_cnt_q;

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      state_q  <= SYNC;
      rx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rx_cnt_d = rx_cnt_q;
    if (s_axis.tvalid) begin
      case (state_q)
        SYNC: if (s_axis.tlast) begin
          state_d  = HEAD;
          rx_cnt_d = '0;
        end
        HEAD: if (s_axis.tlast) begin
          rx_cnt_d = '0;
        end else if (rx_cnt_q == 3'd4) begin
          state_d  = BODY;
          rx_cnt_d = '0;
        end else begin
          rx_cnt_d = rx_cnt_q + 3'd1;
        end
        BODY: if (s_axis.tlast) begin
          state_d  = HEAD;
          rx_cnt_d = '0;
        end
        default: begin
          state_d  = SYNC;
          rx_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    in_vld = s_axis.tvalid && (state_q != SYNC);
    beat0  = s_axis.tvalid && (state_q == HEAD) && (rx_cnt_q == 3'd0);
    beat1  = s_axis.tvalid && (state_q == HEAD) && (rx_cnt_q == 3'd1);
    beat2  = s_axis.tvalid && (state_q == HEAD) && (rx_cnt_q == 3'd2);
    beat4  = s_axis.tvalid && (state_q == HEAD) && (rx_cnt_q == 3'd4);
  end

  always_comb begin
    in_beat      = '0;
    in_beat.vld  = in_vld;
    in_beat.sop  = beat0;
    in_beat.dat  = s_axis.tdata;
    in_beat.keep = s_axis.tkeep;
    in_beat.last = s_axis.tlast;
    in_beat.user = s_axis.tuser;
  end

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[3:0], in_beat};
    end
  end

  assign s5 = pipe_q[4];

  // Ports sit on beat 4 (frame bytes 34..37) and are compared straight off the bus.
  assign dport    = {s_axis.tdata[39:32], s_axis.tdata[47:40]};
  assign sport    = {s_axis.tdata[23:16], s_axis.tdata[31:24]};
  assign port_hit = ((MATCH_SRC ? sport : dport) == filter_port);

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      ftype_q    <= '0;
      verbyte_q  <= '0;
      proto_q    <= '0;
      dec_vld_q  <= 1'b0;
      dec_drop_q <= 1'b0;
    end else begin
      if (beat1) begin
        ftype_q   <= {s_axis.tdata[39:32], s_axis.tdata[47:40]};
        verbyte_q <= s_axis.tdata[55:48];
      end
      if (beat2) begin
        proto_q <= s_axis.tdata[63:56];
      end
      if (beat4) begin
        dec_vld_q  <= 1'b1;
        dec_drop_q <= filter_en && (ftype_q == 16'h0800) && (verbyte_q == 8'h45) &&
                      (proto_q == 8'h11) && port_hit;
      end else if (beat0) begin
        dec_vld_q <= 1'b0;
      end
    end
  end

  // The first beat reads the live decision; later beats of the frame use the latched copy.
  assign drop_now  = (s5.vld && s5.sop) ? (dec_vld_q && dec_drop_q) : out_drop_q;
  assign undec_now = (s5.vld && s5.sop) ? !dec_vld_q : out_undec_q;

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      out_drop_q  <= 1'b0;
      out_undec_q <= 1'b0;
      pass_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      undec_cnt_q <= '0;
    end else begin
      if (s5.vld && s5.sop) begin
        out_drop_q  <= dec_vld_q && dec_drop_q;
        out_undec_q <= !dec_vld_q;
      end
      if (s5.vld && s5.last) begin
        if (drop_now) begin
          drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end else begin
          pass_cnt_q <= pass_cnt_q + CNT_W'(1);
        end
        if (undec_now) begin
          undec_cnt_q <= undec_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign m_axis.tvalid = s5.vld && !drop_now;
  assign m_axis.tdata  = s5.dat;
  assign m_axis.tkeep  = s5.keep;
  assign m_axis.tlast  = s5.last;
  assign m_axis.tuser  = s5.user;

  assign pass_cnt  = pass_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign undec_cnt = undec_cnt_q;
  assign debug     = drop_cnt_q[7:0];

endmodule

// File: tb/tb_eth_udp_drop_filter.sv
// Directed bench for eth_udp_drop_filter: hand-built UDP/ICMP frames, expected beats and counters.
module tb_eth_udp_drop_filter;

  localparam int NB = 10;

  typedef struct {
    int          cyc;
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } ob_t;

  logic        clk156 = 1'b0;
  logic        eth_rst;
  logic        filter_en;
  logic [15:0] filter_port;
  logic [31:0] pass_cnt, drop_cnt, undec_cnt;
  logic [7:0]  debug;

  int  cyc   = 0;
  int  n_chk = 0;
  int  n_err = 0;
  int  seed  = 0;
  ob_t exp_q[$];
  ob_t obs_q[$];

  eth_udp_drop_filter_if s_if ();
  eth_udp_drop_filter_if m_if ();

  eth_udp_drop_filter #(.CNT_W(32), .MATCH_SRC(1'b0)) dut (
    .clk156      (clk156),
    .eth_rst     (eth_rst),
    .filter_en   (filter_en),
    .filter_port (filter_port),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .pass_cnt    (pass_cnt),
    .drop_cnt    (drop_cnt),
    .undec_cnt   (undec_cnt),
    .debug       (debug)
  );

  always #5 clk156 = ~clk156;

  always @(posedge clk156) cyc <= cyc + 1;

  always @(negedge clk156) begin
    if (m_if.tvalid === 1'b1) begin
      obs_q.push_back('{cyc, m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser});
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fbyte(input int n, input logic [7:0] proto, input logic [15:0] dport);
    logic [7:0] b;
    b = 8'((n * 37) + (seed * 11) + 5);
    case (n)
      12: b = 8'h08;
      13: b = 8'h00;
      14: b = 8'h45;
      23: b = proto;
      34: b = 8'hC3;
      35: b = 8'h50;
      36: b = dport[15:8];
      37: b = dport[7:0];
      default: ;
    endcase
    return b;
  endfunction

  task automatic drive_beat(input int i, input logic [7:0] proto, input logic [15:0] dport, input bit rec);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[j*8 +: 8] = fbyte(i * 8 + j, proto, dport);
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tkeep  = (i == NB - 1) ? 8'h3F : 8'hFF;
    s_if.tlast  = (i == NB - 1);
    s_if.tuser  = (i == NB - 1) && seed[0];
    if (rec) exp_q.push_back('{cyc, d, s_if.tkeep, s_if.tlast, s_if.tuser});
    @(posedge clk156); #1;
  endtask

  task automatic idle(input int n);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    repeat (n) begin @(posedge clk156); #1; end
  endtask

  task automatic send_frame(input logic [7:0] proto, input logic [15:0] dport, input bit rec,
                            input int gap_after, input int gap_len);
    seed++;
    for (int i = 0; i < NB; i++) begin
      drive_beat(i, proto, dport, rec);
      if (i == gap_after) idle(gap_len);
    end
  endtask

  // Reset, then one tlast beat so the input side leaves its resync state.
  task automatic do_reset();
    eth_rst = 1'b1;
    idle(2);
    eth_rst = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tlast  = 1'b1;
    s_if.tdata  = 64'hDEAD_BEEF_0000_0001;
    s_if.tkeep  = 8'h01;
    @(posedge clk156); #1;
    idle(2);
  endtask

  task automatic compare_out(input string tag);
    int n;
    chk({tag, "_nbeats"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_lat"},  64'(obs_q[i].cyc - exp_q[i].cyc), 64'd5);
      chk({tag, "_dat"},  obs_q[i].d, exp_q[i].d);
      chk({tag, "_keep"}, 64'(obs_q[i].k), 64'(exp_q[i].k));
      chk({tag, "_last"}, 64'(obs_q[i].l), 64'(exp_q[i].l));
      chk({tag, "_user"}, 64'(obs_q[i].u), 64'(exp_q[i].u));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_cnt(input string tag, input int p, input int d, input int u);
    chk({tag, "_pass"},  64'(pass_cnt),  64'(p));
    chk({tag, "_drop"},  64'(drop_cnt),  64'(d));
    chk({tag, "_undec"}, 64'(undec_cnt), 64'(u));
    chk({tag, "_debug"}, 64'(debug),     64'(8'(d)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    eth_rst     = 1'b1;
    filter_en   = 1'b1;
    filter_port = 16'd53;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    repeat (3) begin @(posedge clk156); #1; end

    chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_tdata",  m_if.tdata, 64'd0);
    chk("rst_tkeep",  64'(m_if.tkeep), 64'd0);
    chk("rst_tlast",  64'(m_if.tlast), 64'd0);
    chk_cnt("rst", 0, 0, 0);

    // Matching UDP dport 53 is dropped entirely.
    do_reset();
    send_frame(8'h11, 16'd53, 1'b0, -1, 0);
    idle(12);
    compare_out("t1");
    chk_cnt("t1", 0, 1, 0);

    // Non-matching dport forwards bit-exact after 5 cycles (odd seed -> tuser set on last beat).
    do_reset();
    seed = 0;
    send_frame(8'h11, 16'd12345, 1'b1, -1, 0);
    idle(12);
    compare_out("t2");
    chk_cnt("t2", 1, 0, 0);

    // Filter disabled: dport 53 is forwarded.
    do_reset();
    filter_en = 1'b0;
    send_frame(8'h11, 16'd53, 1'b1, -1, 0);
    idle(12);
    compare_out("t3");
    chk_cnt("t3", 1, 0, 0);
    filter_en = 1'b1;

    // Back-to-back drop / ICMP pass / drop with no idle cycles.
    do_reset();
    send_frame(8'h11, 16'd53, 1'b0, -1, 0);
    send_frame(8'h01, 16'd53, 1'b1, -1, 0);
    send_frame(8'h11, 16'd53, 1'b0, -1, 0);
    idle(12);
    compare_out("t4");
    chk_cnt("t4", 1, 2, 0);

    // Two-cycle gap between beats 2 and 3: no decision in time, frame fails open.
    do_reset();
    send_frame(8'h11, 16'd53, 1'b1, 2, 2);
    idle(12);
    compare_out("t5");
    chk_cnt("t5", 1, 0, 1);

    // Reset pulse on beat 3: partial frame flushed, tail discarded, counters cleared.
    seed++;
    for (int i = 0; i < NB; i++) begin
      eth_rst = (i == 3);
      drive_beat(i, 8'h11, 16'd12345, 1'b0);
    end
    eth_rst = 1'b0;
    idle(12);
    compare_out("t6_flush");
    chk_cnt("t6_rst", 0, 0, 0);
    send_frame(8'h11, 16'd53, 1'b0, -1, 0);
    idle(12);
    compare_out("t6_next");
    chk_cnt("t6_next", 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
